// File: rtl/cc_speedcounter.sv
// cc_speedcounter: speed-time base for cc_speedcomparator.
// Free-running up-counter that reloads with a level-dependent preload when the
// comparator reports all-ones on T0_InLow. It emits a one-cycle tick once per period.
// The speed level saturates at both ends and is stepped by edge-detected up/down requests.
// A higher level gives a larger preload, which shortens the period.
module cc_speedcounter #(
    parameter int SPEEDCOUNTER_DATAWIDTH  = 23,
    parameter int SPEEDCOUNTER_LEVELWIDTH = 3,
    parameter int SPEEDCOUNTER_LEVELS     = 8,
    parameter logic [SPEEDCOUNTER_DATAWIDTH-1:0] SPEEDCOUNTER_STEP = 23'h0F0000
) (
    input  logic                                 CC_SPEEDCOUNTER_CLOCK_50,
    input  logic                                 CC_SPEEDCOUNTER_RESET_InHigh,
    input  logic                                 CC_SPEEDCOUNTER_enable_InHigh,
    input  logic                                 CC_SPEEDCOUNTER_clear_InHigh,
    input  logic                                 CC_SPEEDCOUNTER_levelUp_InHigh,
    input  logic                                 CC_SPEEDCOUNTER_levelDown_InHigh,
    input  logic                                 CC_SPEEDCOUNTER_T0_InLow,
    output logic [SPEEDCOUNTER_DATAWIDTH-1:0]    CC_SPEEDCOUNTER_data_OutBUS,
    output logic [SPEEDCOUNTER_LEVELWIDTH-1:0]   CC_SPEEDCOUNTER_level_OutBUS,
    output logic                                 CC_SPEEDCOUNTER_tick_OutHigh
);

    localparam int DW = SPEEDCOUNTER_DATAWIDTH;
    localparam int LW = SPEEDCOUNTER_LEVELWIDTH;
    localparam logic [LW-1:0] LEVEL_MAX = LW'(SPEEDCOUNTER_LEVELS - 1);

    // The preload is level * STEP at counter width; parameter limits keep it below all-ones.
    function automatic logic [DW-1:0] preload_f(input logic [LW-1:0] lvl);
        logic [DW-1:0] ext;
        ext          = '0;
        ext[LW-1:0]  = lvl;
        return ext * SPEEDCOUNTER_STEP;
    endfunction

    logic [DW-1:0] data_q,  data_d;
    logic          tick_q,  tick_d;
    logic [LW-1:0] level_q, level_d;
    logic          up_q,    dn_q;
    logic          rise_up_s, rise_dn_s;

    assign rise_up_s = CC_SPEEDCOUNTER_levelUp_InHigh   & ~up_q;
    assign rise_dn_s = CC_SPEEDCOUNTER_levelDown_InHigh & ~dn_q;

    // Count next-state: clear beats reload, and reload beats increment. Disabled means hold.
    // Reload uses the registered (old) level, so a same-cycle level step applies to the next period.
    always_comb begin
        data_d = data_q;
        tick_d = 1'b0;
        if (CC_SPEEDCOUNTER_clear_InHigh) begin
            data_d = preload_f(level_q);
            tick_d = 1'b0;
        end else if (CC_SPEEDCOUNTER_enable_InHigh && !CC_SPEEDCOUNTER_T0_InLow) begin
            data_d = preload_f(level_q);
            tick_d = 1'b1;
        end else if (CC_SPEEDCOUNTER_enable_InHigh) begin
            data_d = data_q + DW'(1);
            tick_d = 1'b0;
        end else begin
            data_d = data_q;
            tick_d = 1'b0;
        end
    end

    // Level next-state: a lone rising request moves one step, saturating at both ends.
    // Simultaneous rising requests cancel each other out.
    always_comb begin
        level_d = level_q;
        if (rise_up_s && !rise_dn_s) begin
            if (level_q != LEVEL_MAX) begin
                level_d = level_q + LW'(1);
            end else begin
                level_d = level_q;
            end
        end else if (rise_dn_s && !rise_up_s) begin
            if (level_q != '0) begin
                level_d = level_q - LW'(1);
            end else begin
                level_d = level_q;
            end
        end else begin
            level_d = level_q;
        end
    end

    // State registers. These include the request edge-detect history and are cleared by async reset.
    always_ff @(posedge CC_SPEEDCOUNTER_CLOCK_50 or posedge CC_SPEEDCOUNTER_RESET_InHigh) begin
        if (CC_SPEEDCOUNTER_RESET_InHigh) begin
            data_q  <= '0;
            tick_q  <= 1'b0;
            level_q <= '0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
        end else begin
            data_q  <= data_d;
            tick_q  <= tick_d;
            level_q <= level_d;
            up_q    <= CC_SPEEDCOUNTER_levelUp_InHigh;
            dn_q    <= CC_SPEEDCOUNTER_levelDown_InHigh;
        end
    end

    assign CC_SPEEDCOUNTER_data_OutBUS  = data_q;
    assign CC_SPEEDCOUNTER_level_OutBUS = level_q;
    assign CC_SPEEDCOUNTER_tick_OutHigh = tick_q;

endmodule

// File: tb/tb_cc_speedcounter.sv
// Testbench for cc_speedcounter (8-bit counter, 4 levels, step 0x40).
// The comparator is modelled as T0 = ~&data. Expected values come from an
// arithmetic reference model of the counting and level rules.
module tb_cc_speedcounter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, clr, up, dn;
    logic       t0_n;
    logic [7:0] dut_data;
    logic [1:0] dut_level;
    logic       dut_tick;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_data, m_level, m_tick, m_up, m_dn;

    always #5 clk = ~clk;

    assign t0_n = ~&dut_data;

    cc_speedcounter #(
        .SPEEDCOUNTER_DATAWIDTH (8),
        .SPEEDCOUNTER_LEVELWIDTH(2),
        .SPEEDCOUNTER_LEVELS    (4),
        .SPEEDCOUNTER_STEP      (8'h40)
    ) dut (
        .CC_SPEEDCOUNTER_CLOCK_50        (clk),
        .CC_SPEEDCOUNTER_RESET_InHigh    (rst),
        .CC_SPEEDCOUNTER_enable_InHigh   (en),
        .CC_SPEEDCOUNTER_clear_InHigh    (clr),
        .CC_SPEEDCOUNTER_levelUp_InHigh  (up),
        .CC_SPEEDCOUNTER_levelDown_InHigh(dn),
        .CC_SPEEDCOUNTER_T0_InLow        (t0_n),
        .CC_SPEEDCOUNTER_data_OutBUS     (dut_data),
        .CC_SPEEDCOUNTER_level_OutBUS    (dut_level),
        .CC_SPEEDCOUNTER_tick_OutHigh    (dut_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_data = 0; m_level = 0; m_tick = 0; m_up = 0; m_dn = 0;
    endtask

    // One clock: advance the model from the pre-edge inputs, then compare after the edge.
    task automatic cycle();
        int ru, rd, nd, nt, nl;
        ru = (up && !m_up) ? 1 : 0;
        rd = (dn && !m_dn) ? 1 : 0;
        nt = 0;
        if (clr)                          nd = (m_level * 64) % 256;
        else if (en && m_data == 255) begin nd = (m_level * 64) % 256; nt = 1; end
        else if (en)                      nd = (m_data + 1) % 256;
        else                              nd = m_data;
        nl = m_level;
        if (ru && !rd)      nl = (m_level < 3) ? m_level + 1 : 3;
        else if (rd && !ru) nl = (m_level > 0) ? m_level - 1 : 0;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else begin
            m_data = nd; m_tick = nt; m_level = nl;
            m_up = up ? 1 : 0; m_dn = dn ? 1 : 0;
        end
        chk("data",  32'(dut_data),  32'(m_data));
        chk("tick",  32'(dut_tick),  32'(m_tick));
        chk("level", 32'(dut_level), 32'(m_level));
    endtask

    task automatic run_until(input int target, input int maxc);
        int n = 0;
        while (m_data != target && n < maxc) begin
            cycle();
            n++;
        end
        chk("reach_target", 32'(dut_data), 32'(target));
    endtask

    task automatic pulse_up();
        up = 1'b1; cycle(); up = 1'b0; cycle();
    endtask

    task automatic pulse_dn();
        dn = 1'b1; cycle(); dn = 1'b0; cycle();
    endtask

    initial begin
        int first_tick;
        int n;
        int period;

        rst = 1'b1; en = 1'b0; clr = 1'b0; up = 1'b0; dn = 1'b0;
        model_reset();
        #1;
        chk("reset_data",  32'(dut_data),  32'h0);
        chk("reset_level", 32'(dut_level), 32'h0);
        chk("reset_tick",  32'(dut_tick),  32'h0);
        cycle(); cycle();
        rst = 1'b0;

        // level 0, free running: the first tick comes on edge 256 (data wrapped from FF to 00)
        en = 1'b1;
        first_tick = 0;
        for (int i = 1; i <= 300; i++) begin
            cycle();
            if (dut_tick === 1'b1 && first_tick == 0) first_tick = i;
        end
        chk("first_tick_cycle", 32'(first_tick), 32'd256);

        // asynchronous reset mid-count, with no clock edge needed
        run_until(8'h37, 300);
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_data",  32'(dut_data),  32'h0);
        chk("async_rst_level", 32'(dut_level), 32'h0);
        chk("async_rst_tick",  32'(dut_tick),  32'h0);
        #1 rst = 1'b0;

        // two level-up pulses give level 2: preload 0x80 and a 128-cycle period
        pulse_up(); pulse_up();
        chk("level_after_2up", 32'(dut_level), 32'd2);
        n = 0;
        while (dut_tick !== 1'b1 && n < 300) begin cycle(); n++; end
        chk("reload_data_L2", 32'(dut_data), 32'h80);
        period = 0;
        do begin cycle(); period++; end while (dut_tick !== 1'b1 && period < 300);
        chk("period_L2", 32'(period), 32'd128);

        // randomized traffic checked against the model
        for (int i = 0; i < 600; i++) begin
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 39) == 0);
            up  = ($urandom_range(0, 7) == 0);
            dn  = ($urandom_range(0, 7) == 0);
            cycle();
        end
        en = 1'b1; clr = 1'b0; up = 1'b0; dn = 1'b0;
        cycle();

        // saturation at the top with levelUp held, then at the bottom
        pulse_up(); pulse_up(); pulse_up();
        chk("level_sat_top", 32'(dut_level), 32'd3);
        up = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        chk("level_held_up", 32'(dut_level), 32'd3);
        up = 1'b0; cycle();
        for (int i = 0; i < 4; i++) pulse_dn();
        chk("level_sat_bottom", 32'(dut_level), 32'd0);
        pulse_dn();
        chk("level_down_at_0", 32'(dut_level), 32'd0);
        pulse_up();
        up = 1'b1; dn = 1'b1; cycle();
        chk("level_up_dn_same", 32'(dut_level), 32'd1);
        up = 1'b0; dn = 1'b0; cycle();

        // clear while disabled at data 0x50, level 1, gives 0x40 with no tick
        run_until(8'h50, 600);
        en = 1'b0; clr = 1'b1;
        cycle();
        chk("clear_data", 32'(dut_data), 32'h40);
        chk("clear_tick", 32'(dut_tick), 32'h0);
        clr = 1'b0; en = 1'b1;

        // pause while sitting at all-ones, then resume
        run_until(8'hFF, 600);
        en = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("pause_data", 32'(dut_data), 32'hFF);
        chk("pause_tick", 32'(dut_tick), 32'h0);
        en = 1'b1;
        cycle();
        chk("resume_data", 32'(dut_data), 32'h40);
        chk("resume_tick", 32'(dut_tick), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
